div_unit: RTL and testbench

Iterative RV32M divider in the EX stage. Executes DIV/DIVU/REM/REMU with a radix-2 restoring algorithm, one quotient bit per cycle. Drives `div_busy_e`, which the hazard unit turns into the `div_stall` pipeline hold (plus one extra registered cycle). Result is muxed into the EX result path while the instruction is still held in EX.

---
 rtl/div_unit.sv | 78 +++++++
 tb/tb_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            ex_advance,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic            is_rem, neg_q, neg_r, sgn, div0, ovf, special, last;
  logic [5:0]      count;
  logic [XLEN-1:0] rem, quo, dvs, a_mag, b_mag, special_res, rem_n, quo_n, fin;
  logic [XLEN:0]   rem_shift, diff;
  always_comb begin
    sgn         = ~op[0];
    a_mag       = (sgn & a[XLEN-1]) ? -a : a;
    b_mag       = (sgn & b[XLEN-1]) ? -b : b;
    div0        = b == '0;
    ovf         = sgn & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    special     = div0 | ovf;
    // in the overflow case the required quotient equals the dividend itself
    special_res = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    rem_shift   = {rem, quo[XLEN-1]};
    // 33-bit subtract: bit XLEN is the borrow, clear means rem_shift >= divisor
    diff        = rem_shift - {1'b0, dvs};
    rem_n       = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    quo_n       = {quo[XLEN-2:0], ~diff[XLEN]};
    fin         = is_rem ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
    last        = count == 6'(XLEN-1);
  end
  always_comb begin
    state_n = state;
    state_n = flush ? IDLE
            : state == IDLE ? (start ? (special ? DONE : RUN) : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : (ex_advance ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      count  <= '0;
      result <= '0;
    end else if (state == IDLE && start && !flush) begin
      is_rem <= op[1];
      neg_q  <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
      neg_r  <= sgn & a[XLEN-1];
      rem    <= '0;
      quo    <= a_mag;
      dvs    <= b_mag;
      count  <= '0;
      if (special) result <= special_res;
    end else if (state == RUN && !flush) begin
      rem   <= rem_n;
      quo   <= quo_n;
      count <= count + 6'd1;
      if (last) result <= fin;
    end
  end
  assign busy = ~rst & ((state == IDLE & start) | state == RUN);
  assign done = state == DONE;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized scoreboard bench for div_unit against a plain-arithmetic RV32M model.
module tb_div_unit;
  logic        clk = 0, rst = 1, start = 0, ex_advance = 0, flush = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done;
  logic [31:0] result;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ex_advance(ex_advance), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      return o[1] ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
    end
    return o[1] ? x % y : x / y;
  endfunction

  function automatic int lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 33;
  endfunction

  // called just after a posedge; leaves control just after a posedge with the unit back in IDLE
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit keep, input string name);
    int n, cyc, l;
    logic [31:0] e;
    e = model(o, x, y);
    l = lat(o, x, y);
    op = o; a = x; b = y; start = 1;
    exp_q.push_back(e);
    n = 0; cyc = 0;
    @(negedge clk);
    while (!done && cyc < 100) begin
      if (busy) n++;
      cyc++;
      if (cyc >= 2) begin a = $urandom; b = $urandom; end
      @(negedge clk);
    end
    check({name, "_latency"}, cyc, l);
    check({name, "_busy_cycles"}, n, l);
    check({name, "_busy_in_done"}, {31'b0, busy}, 0);
    @(posedge clk); #1 ex_advance = 1;
    @(negedge clk);
    check({name, "_hold_done"}, {31'b0, done}, 1);
    check({name, "_hold_result"}, result, e);
    @(posedge clk); #1 ex_advance = 0; start = keep;
  endtask

  initial begin : monitor
    logic pd;
    pd = 0;
    forever begin
      @(negedge clk);
      if (!rst && done && !pd) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL monitor: result %h with no expected value", result);
        end else check("result", result, exp_q.pop_front());
      end
      pd = done;
    end
  end

  initial begin
    logic seen;
    logic [1:0] o;
    logic [31:0] x, y;
    #1;
    start = 1;
    #1;
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_result", result, 0);
    start = 0;
    @(posedge clk); #1 rst = 0;

    do_op(2'b01, 100, 7, 0, "divu_100_7");
    do_op(2'b11, 100, 7, 0, "remu_100_7");
    do_op(2'b00, 32'hFFFF_FFF9, 2, 0, "div_m7_2");
    do_op(2'b10, 32'hFFFF_FFF9, 2, 0, "rem_m7_2");
    do_op(2'b01, 5, 0, 0, "divu_by0");
    do_op(2'b10, 5, 0, 0, "rem_by0");
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");

    // flush ten cycles into RUN
    op = 2'b01; a = 100; b = 7; start = 1;
    repeat (11) @(posedge clk);
    #1 flush = 1; start = 0;
    @(negedge clk);
    check("flush_busy_before", {31'b0, busy}, 1);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    check("flush_busy_after", {31'b0, busy}, 0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen = 1; end
    check("flush_no_done", {31'b0, seen}, 0);
    @(posedge clk); #1;
    do_op(2'b01, 9, 3, 0, "divu_after_flush");

    // asynchronous reset in the middle of RUN
    op = 2'b01; a = 1000; b = 3; start = 1;
    repeat (6) @(posedge clk);
    #2 rst = 1;
    #1 check("rst_busy_async", {31'b0, busy}, 0);
    start = 0;
    @(negedge clk);
    check("rst_done", {31'b0, done}, 0);
    check("rst_result", result, 0);
    @(posedge clk); #1 rst = 0;

    do_op(2'b01, 1000, 10, 1, "b2b_first");
    do_op(2'b01, 77, 5, 0, "b2b_second");

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: y = 32'($urandom_range(1, 15));
        2: begin y = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) x = 32'h8000_0000; end
        3: y = -32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      do_op(o, x, y, i != 39 && $urandom_range(0, 1) == 1, "rand");
    end
    start = 0;
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
